interp_tap_window: RTL
======================

// Module: interp_tap_window
// PURPOSE
//  Multi-channel, depth-parametrised tap window feeding the interpolator datapath.
//  Accepts input samples over a valid/ready handshake and presents NUM_TAPS taps per channel.
//  Holds each full window stable until the polyphase engine signals it is done, then admits the next sample.
//  Sits between the sample source and the interpolation kernel.
// PARAMETERS
//  DATA_WIDTH  19  bits per sample per channel
//  NUM_TAPS    4   window depth (>=2); tap 0 = newest (x[n+2]), tap NUM_TAPS-1 = oldest (x[n-1])
//  NUM_CH      1   independent channels shifted in lockstep (>=1)
// PORTS
//  clk         in   1                           clock
//  rst_n       in   1                           asynchronous reset, active low
//  clr         in   1                           synchronous flush: empty the window, zero the taps
//  s_valid     in   1                           input sample valid
//  s_ready     out  1                           block can accept a sample this cycle
//  s_data      in   NUM_CH*DATA_WIDTH           sample; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  win_valid   out  1                           window full and not yet consumed
//  win_done    in   1                           consumer has finished with the current window
//  win_data    out  NUM_TAPS*NUM_CH*DATA_WIDTH  tap t, channel c at [(t*NUM_CH+c)*DATA_WIDTH +: DATA_WIDTH]
//  fill_level  out  $clog2(NUM_TAPS+1)          number of valid taps, saturates at NUM_TAPS
// BEHAVIOUR
//  Interface: one clock (clk); asynchronous, active-low reset (rst_n).
//  Reset: all taps 0, fill_level 0, state FILL, win_valid 0; s_ready is 1 once rst_n deasserts.
//  Accept: accept = s_valid & s_ready. On accept, all channels shift one tap (tap t <= tap t-1; tap 0 <= s_data).
//    fill_level increments on accept and saturates at NUM_TAPS.
//  FSM states:
//   FILL  (fill_level < NUM_TAPS): s_ready=1, win_valid=0.
//         Moves to VALID when an accept makes fill_level reach NUM_TAPS.
//   VALID: win_valid=1; s_ready = win_done (combinational).
//         win_done & s_valid: shift, stay VALID; the new window is visible next cycle.
//         win_done & !s_valid: go to STALE, taps unchanged.
//         !win_done: hold; taps are frozen regardless of s_valid.
//   STALE: win_valid=0, s_ready=1. An accept shifts and returns to VALID.
//  win_data is registered; it changes only on an accept, clr or reset. Latency from accept to win_data update = 1 cycle.
//  win_done while win_valid=0 is ignored.
//  clr: has priority over everything except reset.
//    While clr=1, s_ready=0 and no accept occurs.
//    Next cycle: taps 0, fill_level 0, state FILL.
//    clr together with win_done: the flush wins.
//  Reset mid-operation: immediate, asynchronous return to the reset values; any in-flight window is discarded.
//  Pure data movement: no arithmetic and no width change; each channel is treated as opaque DATA_WIDTH bits.
// CONFIGURATION
//  PRIME_REPLICATE_EN defined:
//   - The first accept after reset or clr writes s_data into ALL taps (edge replication).
//   - fill_level jumps to NUM_TAPS and state goes to VALID, so the first window is available after 1 sample.
//  PRIME_REPLICATE_EN undefined: NUM_TAPS accepts are required before the first win_valid.
// STRUCTURE
//  interp_pkg holds: FSM state localparams (ST_FILL=2'd0, ST_VALID=2'd1, ST_STALE=2'd2),
//    the default DATA_WIDTH/NUM_TAPS constants, and the tap/channel slice-index functions.
//  Sub-module interp_tap_lane: a single-channel NUM_TAPS delay line with shift_en, clr and prime inputs.
//    NUM_CH instances are generated.
//  The top level owns the FSM, the fill counter and the handshake logic.
// TESTING
//  1 Reset, then 4 accepts of 1,2,3,4 (NUM_TAPS=4, NUM_CH=1):
//    win_valid=1 the cycle after the 4th accept; taps[0..3]=4,3,2,1; fill_level=4.
//  2 VALID, win_done=0, s_valid=1 held for 5 cycles:
//    s_ready=0 throughout; taps unchanged.
//    Then win_done=1 with s_data=5: taps=5,4,3,2 next cycle; win_valid stays 1.
//  3 VALID, win_done=1 pulse with s_valid=0:
//    win_valid=0 (STALE) next cycle; s_ready=1.
//    s_data=9 accepted: win_valid=1 with taps=9,x,x,x shifted correctly.
//  4 clr=1 together with s_valid=1 and win_done=1 in VALID:
//    sample not accepted; next cycle fill_level=0, taps all 0, win_valid=0.
//  5 rst_n pulsed low mid-fill (fill_level=2):
//    outputs return to 0 immediately; refill requires 4 accepts.
//  6 NUM_CH=2, s_data={ch1=0x7FFFF, ch0=0x00001}:
//    lanes stay independent; no bit leakage between channel slices.
//    With PRIME_REPLICATE_EN, a first accept of 7 gives taps=7,7,7,7 and win_valid=1 next cycle.

Source files
------------

// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared definitions for the interpolator tap window:
//   - state_e        : window FSM states (FILL / VALID / STALE)
//   - DEF_*          : default geometry constants
//   - *_lsb()        : slice-index helpers for the flattened sample/tap buses
// -----------------------------------------------------------------------------
package interp_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_VALID = 2'd1,
        ST_STALE = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 19;
    localparam int unsigned DEF_NUM_TAPS   = 4;
    localparam int unsigned DEF_NUM_CH     = 1;

    // LSB of channel ch inside the flattened input sample.
    function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned dw);
        return ch * dw;
    endfunction

    // LSB of tap t inside one lane's flattened tap vector.
    function automatic int unsigned lane_lsb(input int unsigned tap, input int unsigned dw);
        return tap * dw;
    endfunction

    // LSB of (tap, channel) inside the flattened window bus.
    function automatic int unsigned win_lsb(input int unsigned tap, input int unsigned ch,
                                            input int unsigned num_ch, input int unsigned dw);
        return (tap * num_ch + ch) * dw;
    endfunction

endpackage

// File: rtl/interp_tap_window_if.sv
// -----------------------------------------------------------------------------
// interp_tap_window_if
// Sample-in handshake and window-out bus of the interpolator tap window.
//   s_valid/s_ready/s_data      : sample stream (source -> window)
//   win_valid/win_done/win_data : window handoff (window -> polyphase engine)
//   fill_level                  : number of valid taps
// Modports: master = source/consumer side, slave = tap window.
// -----------------------------------------------------------------------------
interface interp_tap_window_if #(
    parameter int unsigned DATA_WIDTH = 19,
    parameter int unsigned NUM_TAPS   = 4,
    parameter int unsigned NUM_CH     = 1
);
    localparam int unsigned FILL_W = $clog2(NUM_TAPS + 1);

    logic                                  s_valid;
    logic                                  s_ready;
    logic [NUM_CH*DATA_WIDTH-1:0]          s_data;
    logic                                  win_valid;
    logic                                  win_done;
    logic [NUM_TAPS*NUM_CH*DATA_WIDTH-1:0] win_data;
    logic [FILL_W-1:0]                     fill_level;

    modport master (
        output s_valid, s_data, win_done,
        input  s_ready, win_valid, win_data, fill_level
    );

    modport slave (
        input  s_valid, s_data, win_done,
        output s_ready, win_valid, win_data, fill_level
    );

endinterface

// File: rtl/interp_tap_lane.sv
// -----------------------------------------------------------------------------
// interp_tap_lane
// Single-channel NUM_TAPS delay line. Tap 0 is the newest sample.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush, all taps to zero (highest priority)
//   shift_en   : shift din into tap 0, older taps move down by one
//   prime      : with shift_en, write din into every tap instead of shifting
//   din        : input sample
//   taps       : flattened taps, tap t at [t*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module interp_tap_lane
    import interp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           shift_en,
    input  logic                           prime,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps
);

    logic [DATA_WIDTH-1:0] r_tap [NUM_TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                r_tap[t] <= '0;
            end
        end else if (clr) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                r_tap[t] <= '0;
            end
        end else if (shift_en) begin
            if (prime) begin
                // Edge replication: the first sample stands in for the missing history.
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_tap[t] <= din;
                end
            end else begin
                r_tap[0] <= din;
                for (int t = 1; t < NUM_TAPS; t++) begin
                    r_tap[t] <= r_tap[t-1];
                end
            end
        end
    end

    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
        assign taps[lane_lsb(t, DATA_WIDTH) +: DATA_WIDTH] = r_tap[t];
    end

endmodule

// File: rtl/interp_tap_window.sv
// -----------------------------------------------------------------------------
// interp_tap_window
// Multi-channel tap window in front of the interpolation kernel. Samples are
// accepted over a valid/ready handshake and shifted into NUM_CH lockstep delay
// lines; a full window is held stable until the consumer raises win_done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (empties window, zeroes taps, blocks accept)
//   bus        : interp_tap_window_if.slave (sample handshake, window, fill_level)
// Configuration:
//   PRIME_REPLICATE_EN : when defined, the first accept after reset/clr fills all
//                        taps with that sample and the window is valid at once.
// -----------------------------------------------------------------------------
module interp_tap_window
    import interp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_TAPS   = DEF_NUM_TAPS,
    parameter int unsigned NUM_CH     = DEF_NUM_CH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    interp_tap_window_if.slave bus
);

    localparam int unsigned       FILL_W = $clog2(NUM_TAPS + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(NUM_TAPS);

`ifdef PRIME_REPLICATE_EN
    localparam bit PRIME_EN = 1'b1;
`else
    localparam bit PRIME_EN = 1'b0;
`endif

    state_e            r_state;
    logic [FILL_W-1:0] r_fill;
    logic              r_win_valid;

    logic              w_ready;
    logic              w_accept;
    logic              w_prime;
    logic [FILL_W-1:0] w_fill_inc;

    // In VALID the window may only advance once the consumer is done with it.
    assign w_ready    = !clr && ((r_state != ST_VALID) || bus.win_done);
    assign w_accept   = bus.s_valid && w_ready;
    // An empty window only exists in FILL, so fill==0 marks the first sample.
    assign w_prime    = PRIME_EN && w_accept && (r_fill == '0);
    assign w_fill_inc = r_fill + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_fill      <= '0;
            r_win_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_FILL;
            r_fill      <= '0;
            r_win_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (w_prime || (w_fill_inc == FULL)) begin
                            r_state     <= ST_VALID;
                            r_fill      <= FULL;
                            r_win_valid <= 1'b1;
                        end else begin
                            r_fill <= w_fill_inc;
                        end
                    end
                end
                ST_VALID: begin
                    // win_done with s_valid shifts and stays VALID (handled by the lanes).
                    if (bus.win_done && !bus.s_valid) begin
                        r_state     <= ST_STALE;
                        r_win_valid <= 1'b0;
                    end
                end
                ST_STALE: begin
                    if (w_accept) begin
                        r_state     <= ST_VALID;
                        r_win_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_FILL;
                    r_fill      <= '0;
                    r_win_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready    = w_ready;
    assign bus.win_valid  = r_win_valid;
    assign bus.fill_level = r_fill;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NUM_TAPS*DATA_WIDTH-1:0] w_lane_taps;

        interp_tap_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_TAPS   (NUM_TAPS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .shift_en (w_accept),
            .prime    (w_prime),
            .din      (bus.s_data[chan_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .taps     (w_lane_taps)
        );

        for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
            assign bus.win_data[win_lsb(t, c, NUM_CH, DATA_WIDTH) +: DATA_WIDTH] =
                w_lane_taps[lane_lsb(t, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

endmodule
